// File: rtl/muldiv_ctrl.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring divider
// sharing one accumulator. Divider hardware is present only when MULDIV_DIV_EN is defined.
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] DataA_i,
    input  logic [WIDTH-1:0] DataB_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);
    localparam int AW = 2*WIDTH + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_reg, state_next;
    logic [AW-1:0]      acc_reg, acc_next;
    logic [WIDTH-1:0]   opnd_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [2:0]         op_reg;
    logic               neg_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               accept, last_iter;
    logic               a_signed, b_signed, sign_a, sign_b, neg_in;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               special;
    logic [WIDTH-1:0]   special_result;
    logic [WIDTH:0]     mul_sum;
    logic [AW-1:0]      mul_acc;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]   mul_fin, div_fin, fin;

    assign accept    = (state_reg == IDLE) && start_i && !flush_i;
    assign last_iter = (cnt_reg == CNT_W'(WIDTH-1));

    // Operand signedness: MULHU/DIVU/REMU fully unsigned, MULHSU signs A only.
    always_comb begin
        a_signed = !(op_i == 3'b011 || op_i == 3'b101 || op_i == 3'b111);
        b_signed = a_signed && (op_i != 3'b010);
        sign_a   = a_signed && DataA_i[WIDTH-1];
        sign_b   = b_signed && DataB_i[WIDTH-1];
        mag_a    = sign_a ? (~DataA_i + 1'b1) : DataA_i;
        mag_b    = sign_b ? (~DataB_i + 1'b1) : DataB_i;
        neg_in   = (op_i[2] && op_i[1]) ? sign_a : (sign_a ^ sign_b);
    end

`ifdef MULDIV_DIV_EN
    logic               div_zero, div_ovf;
    logic [AW-1:0]      div_sh, div_acc;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH-1:0]   div_sel;

    always_comb begin
        div_zero = op_i[2] && (DataB_i == '0);
        div_ovf  = op_i[2] && !op_i[0] && (DataA_i == {1'b1, {(WIDTH-1){1'b0}}}) && (DataB_i == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_result = op_i[1] ? DataA_i : '1;
        else
            special_result = op_i[1] ? '0 : DataA_i;
    end

    // Restoring step: shift left, trial-subtract divisor from the upper half.
    always_comb begin
        div_sh   = acc_reg << 1;
        div_diff = {1'b0, div_sh[AW-1:WIDTH]} - {2'b00, opnd_reg};
        if (div_diff[WIDTH+1])
            div_acc = div_sh;
        else
            div_acc = {div_diff[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};
    end
`else
    assign special        = op_i[2];
    assign special_result = '0;
`endif

    always_comb begin
        mul_sum = acc_reg[AW-1:WIDTH] + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
        mul_acc = {mul_sum, acc_reg[WIDTH-1:0]} >> 1;
`ifdef MULDIV_DIV_EN
        acc_next = op_reg[2] ? div_acc : mul_acc;
`else
        acc_next = mul_acc;
`endif
    end

    // Final result is formed from the last iteration's output as DONE is entered.
    always_comb begin
        prod_mag = acc_next[2*WIDTH-1:0];
        prod     = neg_reg ? (~prod_mag + 1'b1) : prod_mag;
        mul_fin  = (op_reg[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
        div_sel  = op_reg[1] ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
        div_fin  = neg_reg ? (~div_sel + 1'b1) : div_sel;
`else
        div_fin  = '0;
`endif
        fin      = op_reg[2] ? div_fin : mul_fin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = special ? DONE : CALC;
            CALC:    if (flush_i) state_next = IDLE;
                     else if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_reg == IDLE);
        busy_o  = (state_reg == CALC) || (state_reg == DONE);
        valid_o = (state_reg == DONE) && !flush_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg    <= '0;
            opnd_reg   <= '0;
            result_reg <= '0;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else if (accept) begin
            op_reg   <= op_i;
            neg_reg  <= neg_in;
            cnt_reg  <= '0;
            acc_reg  <= {{(WIDTH+1){1'b0}}, mag_a};
            opnd_reg <= mag_b;
            if (special)
                result_reg <= special_result;
        end else if (state_reg == CALC && !flush_i) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_iter)
                result_reg <= fin;
        end
    end

    assign result_o = result_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed RV32M vectors, randomized operations against
// an arithmetic reference model, flush/abort, async reset and issue-interval scenarios.
module tb_muldiv_ctrl;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] DataA_i;
    logic [WIDTH-1:0] DataB_i;
    logic             flush_i;
    logic             ready_o;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .DataA_i(DataA_i), .DataB_i(DataB_i), .flush_i(flush_i),
        .ready_o(ready_o), .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output int lat);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        lat = 33;
        res = '0;
        case (op)
            3'd0: begin p = ua * ub;           res = p[31:0];  end
            3'd1: begin p = sa * sb;           res = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); res = p[63:32]; end
            3'd3: begin p = ua * ub;           res = p[63:32]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    lat = 1;
                    res = op[1] ? a : 32'hFFFF_FFFF;
                end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lat = 1;
                    res = op[1] ? 32'd0 : 32'h8000_0000;
                end else begin
                    case (op)
                        3'd4:    res = 32'(sa / sb);
                        3'd5:    res = 32'(ua / ub);
                        3'd6:    res = 32'(sa % sb);
                        default: res = 32'(ua % ub);
                    endcase
                end
`else
                lat = 1;
                res = 32'd0;
`endif
            end
        endcase
    endfunction

    // One transaction: accept, watch latency/busy, check result and the one-cycle strobe.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          lat, cyc;
        bit          busy_ok;
        model(op, a, b, exp, lat);
        @(negedge clk);
        start_i = 1'b1; op_i = op; DataA_i = a; DataB_i = b;
        @(negedge clk);
        start_i = 1'b0; DataA_i = $urandom; DataB_i = $urandom;
        cyc = 1; busy_ok = 1'b1;
        while (!valid_o && cyc < 40) begin
            if (!busy_o) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (!busy_o) busy_ok = 1'b0;
        $display("[TB] op=%0d a=%h b=%h result=%h expected=%h cycle=%0d", op, a, b, result_o, exp, cyc);
        n_tests++;
        if (cyc !== lat) begin
            n_fail++; $display("FAIL latency op=%0d: got cycle %0d, expected %0d", op, cyc, lat);
        end
        n_tests++;
        if (result_o !== exp) begin
            n_fail++; $display("FAIL result op=%0d a=%h b=%h: got %h, expected %h", op, a, b, result_o, exp);
        end
        n_tests++;
        if (!busy_ok) begin
            n_fail++; $display("FAIL busy op=%0d: busy_o dropped before valid, expected 1", op);
        end
        @(negedge clk);
        n_tests++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== exp) begin
            n_fail++;
            $display("FAIL post_done: valid=%b ready=%b result=%h, expected 0 1 %h", valid_o, ready_o, result_o, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; DataA_i = '0; DataB_i = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== '0) begin
            n_fail++;
            $display("FAIL reset: ready=%b busy=%b valid=%b result=%h, expected 1 0 0 0", ready_o, busy_o, valid_o, result_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'd7,          32'hFFFF_FFFD);
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000);
        run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2);
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2);
        run_op(3'd5, 32'd5,          32'd0);
        run_op(3'd7, 32'd5,          32'd0);
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 48; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_op(3'($urandom_range(0, 7)), a, b);
        end
    endtask

    task automatic test_flush();
        bit seen;
        run_op(3'd0, 32'd3, 32'd5);
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; DataA_i = 32'd1234; DataB_i = 32'd5678;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        n_tests++;
        if (ready_o !== 1'b1 || result_o !== 32'd15) begin
            n_fail++; $display("FAIL flush_calc: ready=%b result=%h, expected 1 0000000f", ready_o, result_o);
        end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (valid_o) seen = 1'b1; end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL flush_no_valid: valid_o seen=1, expected 0");
        end
        // New op with a stray start mid-flight that must not resample operands.
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; DataA_i = 32'd5; DataB_i = 32'd6;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; DataA_i = 32'd100; DataB_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        begin
            int cyc = 6;
            while (!valid_o && cyc < 45) begin @(negedge clk); cyc++; end
            $display("[TB] mid-op start: result=%h cycle=%0d", result_o, cyc);
            n_tests++;
            if (cyc !== 33 || result_o !== 32'd30) begin
                n_fail++; $display("FAIL busy_start_ignored: cycle %0d result %h, expected 33 0000001e", cyc, result_o);
            end
        end
        @(negedge clk);
        // Flush landing in DONE suppresses the strobe.
        start_i = 1'b1; op_i = 3'd0; DataA_i = 32'd9; DataB_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (32) @(negedge clk);
        flush_i = 1'b1;
        #1;
        n_tests++;
        if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_done: valid=%b busy=%b, expected 0 1", valid_o, busy_o);
        end
        @(negedge clk);
        flush_i = 1'b0;
        n_tests++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_done_idle: ready=%b valid=%b, expected 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_start_flush_idle();
        bit seen = 1'b0;
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; DataA_i = 32'd2; DataB_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        n_tests++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL start_flush_idle: ready=%b busy=%b, expected 1 0", ready_o, busy_o);
        end
        repeat (36) begin @(negedge clk); if (valid_o) seen = 1'b1; end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL start_flush_no_valid: valid_o seen=1, expected 0");
        end
    endtask

    task automatic test_async_reset();
        run_op(3'd0, 32'd11, 32'd13);
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; DataA_i = $urandom; DataB_i = $urandom;
        @(negedge clk);
        start_i = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== '0) begin
            n_fail++;
            $display("FAIL async_reset: ready=%b busy=%b valid=%b result=%h, expected 1 0 0 0", ready_o, busy_o, valid_o, result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd0, 32'd3, 32'd4);
    endtask

    task automatic test_back_to_back();
        int t = 0, last = -1, pulses = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = 3'd0; DataA_i = 32'd9; DataB_i = 32'd11;
        while (pulses < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (valid_o) begin
                if (last >= 0) begin
                    n_tests++;
                    if (t - last !== WIDTH + 2) begin
                        n_fail++; $display("FAIL issue_interval: got %0d, expected %0d", t - last, WIDTH + 2);
                    end
                end
                n_tests++;
                if (result_o !== 32'd99) begin
                    n_fail++; $display("FAIL back_to_back_result: got %h, expected 00000063", result_o);
                end
                $display("[TB] back-to-back pulse %0d at t=%0d result=%h", pulses, t, result_o);
                last = t;
                pulses++;
            end
        end
        start_i = 1'b0;
        n_tests++;
        if (pulses !== 3) begin
            n_fail++; $display("FAIL back_to_back_count: got %0d pulses, expected 3", pulses);
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_flush_idle();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
